// File: rtl/sabinn_wb_seq_ctrl.sv
// sabinn_wb_seq_ctrl
//   Wishbone-mapped sequencer for one binarized (XNOR-popcount) layer.
//   The management SoC writes INPUT, THRESH and WEIGHT[n], then pulses
//   START. The sequencer evaluates one neuron per clock and packs each
//   sign bit into RESULT. When it finishes it sets DONE, which can drive
//   user_irq[0].
//
// Ports
//   wb_clk_i   : single clock
//   wb_rst_ni  : asynchronous, active-low reset
//   wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i[3:0], wbs_adr_i[31:0],
//   wbs_dat_i[31:0]  : Wishbone slave request
//   wbs_ack_o  : single-cycle acknowledge, one cycle after the request
//   wbs_dat_o  : read data, valid only while wbs_ack_o is high (0 otherwise)
//   user_irq   : [0] = done & irq_en, [2:1] tied low
//
// Register map (byte offset inside the 4 KiB window)
//   0x000 CTRL    W [0] start pulse (reads 0), R/W [1] irq_en; lane 0 only
//   0x004 STATUS  R [0] busy, [1] done, [12:8] idx; write 1 to [1] clears done
//   0x008 INPUT   R/W, byte-lane masked
//   0x00C THRESH  R/W [5:0], lane 0 only
//   0x010 RESULT  RO [NEURONS-1:0]
//   0x100+4n WEIGHT[n]  R/W, byte-lane masked
module sabinn_wb_seq_ctrl #(
  parameter int          BITS      = 32,
  parameter int          NEURONS   = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [2:0]  user_irq
);

  localparam int PCW   = $clog2(BITS + 1);
  localparam int IDX_W = 5;
  localparam int NIW   = (NEURONS > 1) ? $clog2(NEURONS) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e state_q, state_d;
  logic   busy;

  logic              ack_q;
  logic [31:0]       dat_q;
  logic              irq_en_q;
  logic              done_q;
  logic [IDX_W-1:0]  idx_q;
  logic [NEURONS-1:0] result_q;
  logic [BITS-1:0]   input_q;
  logic [PCW-1:0]    thresh_q;
  logic [BITS-1:0]   weight_q [NEURONS];

  function automatic logic [PCW-1:0] popcount(input logic [BITS-1:0] v);
    logic [PCW-1:0] c;
    c = '0;
    for (int i = 0; i < BITS; i++) c = c + PCW'(v[i]);
    return c;
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  // Address decode. The ack register gates a new request so that a master
  // holding STB sees ack at most every other cycle.
  logic       hit, req, wr, wr_ok, start_wr, last;
  logic [9:0] woff;
  logic       is_ctrl, is_status, is_input, is_thresh, w_hit;
  logic [NIW-1:0] widx_n, idx_n;
  logic       neuron_bit;
  logic [31:0] rdata;
  logic [1:0] unused_adr;

  assign unused_adr = wbs_adr_i[1:0];
  assign hit        = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign req        = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
  assign wr         = req & wbs_we_i;
  assign wr_ok      = wr & ~busy;
  assign woff       = wbs_adr_i[11:2];
  assign is_ctrl    = (woff == 10'h000);
  assign is_status  = (woff == 10'h001);
  assign is_input   = (woff == 10'h002);
  assign is_thresh  = (woff == 10'h003);
  assign w_hit      = (woff[9:5] == 5'b00010) && ({1'b0, woff[4:0]} < 6'(NEURONS));
  assign widx_n     = woff[NIW-1:0];
  assign idx_n      = idx_q[NIW-1:0];
  assign start_wr   = wr & is_ctrl & wbs_sel_i[0] & wbs_dat_i[0] & ~busy;
  assign last       = (idx_q == IDX_W'(NEURONS - 1));
  assign neuron_bit = (popcount(~(input_q ^ weight_q[idx_n])) >= thresh_q);

  always_comb begin
    rdata = '0;
    case (woff)
      10'h000: rdata[1] = irq_en_q;
      10'h001: begin
        rdata[0]    = busy;
        rdata[1]    = done_q;
        rdata[12:8] = idx_q;
      end
      10'h002: rdata = input_q;
      10'h003: rdata[PCW-1:0] = thresh_q;
      10'h004: rdata[NEURONS-1:0] = result_q;
      default: if (w_hit) rdata = weight_q[widx_n];
    endcase
  end

  // FSM state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_wr) state_d = RUN;
      RUN:     if (last)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == RUN);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      input_q  <= '0;
      thresh_q <= '0;
      for (int n = 0; n < NEURONS; n++) weight_q[n] <= '0;
    end else begin
      ack_q <= req;
      dat_q <= (req && !wbs_we_i) ? rdata : 32'h0;

      if (wr && is_ctrl && wbs_sel_i[0]) irq_en_q <= wbs_dat_i[1];

      // Hardware set of done beats a simultaneous write-1-to-clear.
      if (busy && last)
        done_q <= 1'b1;
      else if (start_wr)
        done_q <= 1'b0;
      else if (wr && is_status && wbs_sel_i[0] && wbs_dat_i[1])
        done_q <= 1'b0;

      if (start_wr) begin
        idx_q    <= '0;
        result_q <= '0;
      end else if (busy) begin
        result_q[idx_n] <= neuron_bit;
        idx_q           <= last ? '0 : idx_q + IDX_W'(1);
      end

      if (wr_ok && is_input)
        input_q <= lane_merge(input_q, wbs_dat_i, wbs_sel_i);
      if (wr_ok && is_thresh && wbs_sel_i[0])
        thresh_q <= wbs_dat_i[PCW-1:0];
      if (wr_ok && w_hit)
        weight_q[widx_n] <= lane_merge(weight_q[widx_n], wbs_dat_i, wbs_sel_i);
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign user_irq  = {2'b00, done_q & irq_en_q};

endmodule

// File: tb/tb_sabinn_wb_seq_ctrl.sv
// Testbench for sabinn_wb_seq_ctrl: register-map table, directed layer runs
// and randomized runs compared with a popcount model of the layer.
module tb_sabinn_wb_seq_ctrl;

  localparam int          N    = 16;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = '0, dat_w = '0;
  logic        ack;
  logic [31:0] dat_r;
  logic [2:0]  irq;

  sabinn_wb_seq_ctrl #(.BITS(32), .NEURONS(N), .BASE_ADDR(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(dat_w),
    .wbs_ack_o(ack),
    .wbs_dat_o(dat_r),
    .user_irq (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the programmable state
  logic [31:0] m_in;
  logic [5:0]  m_th;
  logic [31:0] m_w [N];

  typedef struct {
    logic [11:0] off;
    logic        w;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_in = '0;
    m_th = '0;
    for (int n = 0; n < N; n++) m_w[n] = '0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Each neuron fires when the number of agreeing bits reaches the threshold.
  function automatic logic [31:0] exp_result();
    logic [31:0] r;
    r = '0;
    for (int n = 0; n < N; n++)
      if ($countones(~(m_in ^ m_w[n])) >= int'(m_th)) r[n] = 1'b1;
    return r;
  endfunction

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output bit acked);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = d; sel = s;
    acked = 1'b0;
    rd = '0;
    for (int i = 0; i < 8 && !acked; i++) begin
      @(posedge clk); #1;
      if (ack) begin
        acked = 1'b1;
        rd = dat_r;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [11:0] off, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    bit acked;
    bus(BASE | {20'h0, off}, 1'b1, d, s, rd, acked);
    check("write_ack", {31'h0, acked}, 32'h1);
  endtask

  task automatic rd(input logic [11:0] off, output logic [31:0] v);
    bit acked;
    bus(BASE | {20'h0, off}, 1'b0, 32'h0, 4'hF, v, acked);
    check("read_ack", {31'h0, acked}, 32'h1);
  endtask

  task automatic rd_chk(input string name, input logic [11:0] off, input logic [31:0] exp);
    logic [31:0] v;
    rd(off, v);
    check(name, v, exp);
  endtask

  // Write through to the DUT and mirror the write in the model (idle only).
  task automatic m_wr(input logic [11:0] off, input logic [31:0] d, input logic [3:0] s);
    wr(off, d, s);
    if (off == 12'h008) m_in = merge(m_in, d, s);
    else if (off == 12'h00C && s[0]) m_th = d[5:0];
    else if (off >= 12'h100 && off < 12'h100 + 12'(4 * N)) begin
      int n;
      n = int'((off - 12'h100) >> 2);
      m_w[n] = merge(m_w[n], d, s);
    end
  endtask

  task automatic wait_irq(input string name, output time t);
    bit seen;
    seen = 1'b0;
    t = $time;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      if (irq[0]) begin
        seen = 1'b1;
        t = $time;
      end
    end
    check(name, {31'h0, seen}, 32'h1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Start a run with irq enabled and check latency, RESULT and STATUS.
  task automatic run_check(input string name);
    time t0, t1;
    wr(12'h000, 32'h3, 4'hF);
    t0 = $time;
    check({name, "_irq_low_at_start"}, {29'h0, irq}, 32'h0);
    wait_irq({name, "_done"}, t1);
    check({name, "_busy_cycles"}, 32'((t1 - t0) / 10), 32'd16);
    rd_chk({name, "_result"}, 12'h010, exp_result());
    rd_chk({name, "_status"}, 12'h004, 32'h2);
  endtask

  initial begin
    logic [31:0] v;
    logic [3:0]  pat;
    logic [31:0] dummy;
    bit          acked;
    time         t0, t1;

    tbl[0]  = '{12'h004, 1'b0, 32'h0,        4'hF, 32'h0};
    tbl[1]  = '{12'h010, 1'b0, 32'h0,        4'hF, 32'h0};
    tbl[2]  = '{12'h008, 1'b0, 32'h0,        4'hF, 32'h0};
    tbl[3]  = '{12'h100, 1'b0, 32'h0,        4'hF, 32'h0};
    tbl[4]  = '{12'h008, 1'b1, 32'h12345678, 4'hF, 32'h0};
    tbl[5]  = '{12'h008, 1'b0, 32'h0,        4'hF, 32'h12345678};
    tbl[6]  = '{12'h008, 1'b1, 32'hFFFFFFFF, 4'h5, 32'h0};
    tbl[7]  = '{12'h008, 1'b0, 32'h0,        4'hF, 32'h12FF56FF};
    tbl[8]  = '{12'h00C, 1'b1, 32'hFFFFFF2A, 4'hF, 32'h0};
    tbl[9]  = '{12'h00C, 1'b0, 32'h0,        4'hF, 32'h2A};
    tbl[10] = '{12'h00C, 1'b1, 32'h0000003F, 4'hE, 32'h0};
    tbl[11] = '{12'h00C, 1'b0, 32'h0,        4'hF, 32'h2A};
    tbl[12] = '{12'h000, 1'b1, 32'h2,        4'hF, 32'h0};
    tbl[13] = '{12'h000, 1'b0, 32'h0,        4'hF, 32'h2};
    tbl[14] = '{12'h000, 1'b1, 32'h0,        4'hF, 32'h0};
    tbl[15] = '{12'h000, 1'b0, 32'h0,        4'hF, 32'h0};
    tbl[16] = '{12'h020, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0};
    tbl[17] = '{12'h020, 1'b0, 32'h0,        4'hF, 32'h0};
    tbl[18] = '{12'h10C, 1'b1, 32'hCAFEBABE, 4'hF, 32'h0};
    tbl[19] = '{12'h10C, 1'b0, 32'h0,        4'hF, 32'hCAFEBABE};
    tbl[20] = '{12'h13C, 1'b1, 32'hAB123456, 4'h8, 32'h0};
    tbl[21] = '{12'h13C, 1'b0, 32'h0,        4'hF, 32'hAB000000};
    tbl[22] = '{12'h140, 1'b0, 32'h0,        4'hF, 32'h0};
    tbl[23] = '{12'h010, 1'b1, 32'h0000FFFF, 4'hF, 32'h0};
    tbl[24] = '{12'h010, 1'b0, 32'h0,        4'hF, 32'h0};
    tbl[25] = '{12'h004, 1'b0, 32'h0,        4'hF, 32'h0};

    // Reset held for three cycles
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_irq", {29'h0, irq}, 32'h0);
    check("rst_dat", dat_r, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Register map table
    for (int i = 0; i < 26; i++) begin
      if (tbl[i].w) wr(tbl[i].off, tbl[i].d, tbl[i].s);
      else begin
        rd(tbl[i].off, v);
        check($sformatf("tbl_rd_%0d", i), v, tbl[i].exp);
      end
    end
    do_reset();

    // Held request: ack must not come back to back
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'h4; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pat[3-i] = ack;
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("ack_pattern", {28'h0, pat}, 32'hA);

    // Requests outside the window get no ack
    bus(32'h3000_1008, 1'b1, 32'hFFFF_FFFF, 4'hF, dummy, acked);
    check("nomatch_ack_1", {31'h0, acked}, 32'h0);
    bus(32'h2000_0008, 1'b0, 32'h0, 4'hF, dummy, acked);
    check("nomatch_ack_2", {31'h0, acked}, 32'h0);
    rd_chk("nomatch_no_write", 12'h008, 32'h0);

    // All weights equal the input, threshold 32
    m_wr(12'h008, 32'hA5A5A5A5, 4'hF);
    for (int n = 0; n < N; n++) m_wr(12'h100 + 12'(4 * n), 32'hA5A5A5A5, 4'hF);
    m_wr(12'h00C, 32'd32, 4'hF);
    run_check("t2");
    rd_chk("t2_result_const", 12'h010, 32'h0000FFFF);
    check("t5_irq_on_done", {29'h0, irq}, 32'h1);

    // Clearing done drops the interrupt on the commit edge
    wr(12'h004, 32'h2, 4'hF);
    check("t5_irq_cleared", {29'h0, irq}, 32'h0);
    rd_chk("t5_status_cleared", 12'h004, 32'h0);

    // Odd weights inverted, threshold 1
    for (int n = 0; n < N; n++)
      m_wr(12'h100 + 12'(4 * n), (n % 2 == 1) ? ~m_in : m_in, 4'hF);
    m_wr(12'h00C, 32'd1, 4'hF);
    run_check("t3");
    rd_chk("t3_result_const", 12'h010, 32'h00005555);

    // Writes and a second START during a run are acked but ignored
    for (int n = 0; n < N; n++) m_wr(12'h100 + 12'(4 * n), 32'hA5A5A5A5, 4'hF);
    m_wr(12'h00C, 32'd32, 4'hF);
    wr(12'h000, 32'h3, 4'hF);
    t0 = $time;
    repeat (4) @(posedge clk);
    #1;
    wr(12'h008, 32'h0, 4'hF);
    wr(12'h000, 32'h3, 4'hF);
    wait_irq("t4_done", t1);
    check("t4_busy_cycles", 32'((t1 - t0) / 10), 32'd16);
    rd_chk("t4_result", 12'h010, exp_result());
    rd_chk("t4_result_const", 12'h010, 32'h0000FFFF);
    rd_chk("t4_input_kept", 12'h008, 32'hA5A5A5A5);

    // done W1C landing on the same edge that sets done: set wins
    wr(12'h000, 32'h3, 4'hF);
    repeat (15) @(posedge clk);
    #1;
    wr(12'h004, 32'h2, 4'hF);
    check("w1c_collision_irq", {29'h0, irq}, 32'h1);
    rd_chk("w1c_collision_status", 12'h004, 32'h2);

    // Randomized layers against the popcount model
    for (int it = 0; it < 8; it++) begin
      logic [3:0] s;
      s = 4'($urandom_range(1, 15));
      m_wr(12'h008, $urandom, s);
      for (int n = 0; n < N; n++) begin
        logic [31:0] w;
        case ($urandom_range(0, 3))
          0:       w = $urandom;
          1:       w = m_in;
          2:       w = ~m_in;
          default: w = m_in ^ (32'h1 << $urandom_range(0, 31));
        endcase
        m_wr(12'h100 + 12'(4 * n), w, 4'hF);
      end
      case ($urandom_range(0, 3))
        0:       m_wr(12'h00C, 32'd0, 4'hF);
        1:       m_wr(12'h00C, 32'd32, 4'hF);
        2:       m_wr(12'h00C, 32'($urandom_range(33, 63)), 4'hF);
        default: m_wr(12'h00C, 32'($urandom_range(1, 32)), 4'hF);
      endcase
      run_check($sformatf("rand%0d", it));
    end

    // Threshold above the vector width: no neuron fires
    m_wr(12'h00C, 32'd33, 4'hF);
    for (int n = 0; n < N; n++) m_wr(12'h100 + 12'(4 * n), m_in, 4'hF);
    run_check("th33");
    rd_chk("th33_const", 12'h010, 32'h0);

    // Threshold 0: every neuron fires
    m_wr(12'h00C, 32'd0, 4'hF);
    for (int n = 0; n < N; n++) m_wr(12'h100 + 12'(4 * n), ~m_in, 4'hF);
    run_check("th0");
    rd_chk("th0_const", 12'h010, 32'h0000FFFF);

    // Asynchronous reset clears a pending interrupt between edges
    check("pre_async_irq", {29'h0, irq}, 32'h1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_irq_clear", {29'h0, irq}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Reset in the middle of a run
    m_wr(12'h008, 32'h0F0F0F0F, 4'hF);
    m_wr(12'h100, 32'h0F0F0F0F, 4'hF);
    m_wr(12'h00C, 32'd0, 4'hF);
    wr(12'h000, 32'h3, 4'hF);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_irq", {29'h0, irq}, 32'h0);
    check("t6_ack", {31'h0, ack}, 32'h0);
    check("t6_dat", dat_r, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    rd_chk("t6_status", 12'h004, 32'h0);
    rd_chk("t6_result", 12'h010, 32'h0);
    rd_chk("t6_weight0", 12'h100, 32'h0);
    rd_chk("t6_input", 12'h008, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    check("t6_no_restart_irq", {29'h0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
